// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that multiplexes execution-unit results
// onto the single common data bus, registered one cycle after the grant.
module cdb_arbiter #(
  parameter int NUM_EXU   = 4,
  parameter int TAG_W     = 4,
  parameter int ROB_DEPTH = 16,
  parameter int ROB_PTR_W = $clog2(ROB_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [NUM_EXU-1:0]             exu_req,
  output logic [NUM_EXU-1:0]             exu_rdy,
  input  logic [NUM_EXU*TAG_W-1:0]       exu_tag,
  input  logic [NUM_EXU*32-1:0]          exu_wdata,
  input  logic [NUM_EXU*ROB_PTR_W-1:0]   exu_inst_id,
  output logic                           cdb_wr,
  output logic [TAG_W-1:0]               cdb_tag,
  output logic [31:0]                    cdb_wdata,
  output logic [ROB_PTR_W-1:0]           cdb_inst_id
);

  localparam int PTR_W = (NUM_EXU > 1) ? $clog2(NUM_EXU) : 1;

  logic [PTR_W-1:0]     r_ptr;
  logic                 r_wr;
  logic [TAG_W-1:0]     r_tag;
  logic [31:0]          r_wdata;
  logic [ROB_PTR_W-1:0] r_id;

  logic                 w_gnt;
  logic [PTR_W-1:0]     w_win;
  logic [PTR_W-1:0]     w_nxt;
  logic [TAG_W-1:0]     w_tag;
  logic [31:0]          w_wdata;
  logic [ROB_PTR_W-1:0] w_id;

  // First requester at or after r_ptr, wrapping around.
  always_comb begin
    w_gnt = 1'b0;
    w_win = '0;
    for (int k = 0; k < NUM_EXU; k++) begin
      if (!w_gnt && exu_req[(int'(r_ptr) + k) % NUM_EXU]) begin
        w_gnt = 1'b1;
        w_win = PTR_W'((int'(r_ptr) + k) % NUM_EXU);
      end
    end
    if (!rst_n || flush) begin
      w_gnt = 1'b0;
    end
  end

  always_comb begin
    exu_rdy = '0;
    if (w_gnt) begin
      exu_rdy[w_win] = 1'b1;
    end
  end

  assign w_nxt   = PTR_W'((int'(w_win) + 1) % NUM_EXU);
  assign w_tag   = exu_tag[int'(w_win)*TAG_W +: TAG_W];
  assign w_wdata = exu_wdata[int'(w_win)*32 +: 32];
  assign w_id    = exu_inst_id[int'(w_win)*ROB_PTR_W +: ROB_PTR_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_wr    <= 1'b0;
      r_tag   <= '0;
      r_wdata <= '0;
      r_id    <= '0;
    end else begin
      r_wr <= w_gnt;
      if (w_gnt) begin
        r_ptr   <= w_nxt;
        r_tag   <= w_tag;
        r_wdata <= w_wdata;
        r_id    <= w_id;
      end
    end
  end

  assign cdb_wr      = r_wr;
  assign cdb_tag     = r_tag;
  assign cdb_wdata   = r_wdata;
  assign cdb_inst_id = r_id;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter against a
// cycle-level round-robin reference model.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 4;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [N-1:0]    exu_req;
  logic [N-1:0]    exu_rdy;
  logic [N*TW-1:0] exu_tag;
  logic [N*32-1:0] exu_wdata;
  logic [N*IW-1:0] exu_inst_id;
  logic            cdb_wr;
  logic [TW-1:0]   cdb_tag;
  logic [31:0]     cdb_wdata;
  logic [IW-1:0]   cdb_inst_id;

  logic [TW-1:0] t_tag [N];
  logic [31:0]   t_dat [N];
  logic [IW-1:0] t_id  [N];

  int m_ptr;
  logic m_wr;
  logic [TW-1:0] m_tag;
  logic [31:0]   m_dat;
  logic [IW-1:0] m_id;

  int n_vec;
  int n_err;

  cdb_arbiter #(.NUM_EXU(N), .TAG_W(TW), .ROB_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .exu_req(exu_req), .exu_rdy(exu_rdy),
    .exu_tag(exu_tag), .exu_wdata(exu_wdata),
    .exu_inst_id(exu_inst_id),
    .cdb_wr(cdb_wr), .cdb_tag(cdb_tag),
    .cdb_wdata(cdb_wdata), .cdb_inst_id(cdb_inst_id)
  );

  always #5 clk = ~clk;

  always_comb begin
    exu_tag = '0;
    exu_wdata = '0;
    exu_inst_id = '0;
    for (int i = 0; i < N; i++) begin
      exu_tag[i*TW +: TW]     = t_tag[i];
      exu_wdata[i*32 +: 32]   = t_dat[i];
      exu_inst_id[i*IW +: IW] = t_id[i];
    end
  end

  // Reference: scan requesters from the pointer, wrap, first wins.
  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    g = '0;
    if (rst_n === 1'b1 && flush === 1'b0) begin
      for (int k = 0; k < N; k++) begin
        if (g == '0 && exu_req[(m_ptr + k) % N]) begin
          g[(m_ptr + k) % N] = 1'b1;
        end
      end
    end
    return g;
  endfunction

  task automatic tick();
    logic [N-1:0] g;
    logic r;
    g = model_grant();
    r = rst_n;
    @(posedge clk);
    if (!r) begin
      m_ptr = 0; m_wr = 0; m_tag = '0; m_dat = '0; m_id = '0;
    end else begin
      m_wr = (g != '0);
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          m_tag = t_tag[i]; m_dat = t_dat[i]; m_id = t_id[i];
          m_ptr = (i + 1) % N;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    exu_req = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      t_tag[i] = TW'($urandom);
      t_dat[i] = $urandom;
      t_id[i]  = IW'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    exu_req = '1;
    rand_payload();
    #1;
    n_vec++;
    if (exu_rdy !== '0) begin
      n_err++;
      $display("FAIL reset_rdy got=%b exp=0000", exu_rdy);
    end
    tick();
    tick();
    n_vec++;
    if ({cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id} !== '0) begin
      n_err++;
      $display("FAIL reset_cdb got wr=%b tag=%h d=%h id=%h exp all 0",
               cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id);
    end
    rst_n = 1'b1;
    exu_req = '0;
  endtask

  task automatic test_single();
    do_reset();
    t_tag[2] = 4'd5;
    t_dat[2] = 32'hDEADBEEF;
    t_id[2]  = 4'd9;
    exu_req = 4'b0100;
    #1;
    n_vec++;
    if (exu_rdy !== 4'b0100) begin
      n_err++;
      $display("FAIL single_rdy got=%b exp=0100", exu_rdy);
    end
    tick();
    exu_req = '0;
    n_vec++;
    if (cdb_wr !== 1'b1 || cdb_tag !== 4'd5 ||
        cdb_wdata !== 32'hDEADBEEF || cdb_inst_id !== 4'd9) begin
      n_err++;
      $display("FAIL single_cdb got wr=%b tag=%0d d=%h id=%0d exp 1/5/deadbeef/9",
               cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id);
    end
    tick();
    n_vec++;
    if (cdb_wr !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle got wr=%b exp=0", cdb_wr);
    end
  endtask

  task automatic test_all_req();
    logic [N-1:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    rand_payload();
    do_reset();
    exu_req = '1;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++;
      if (exu_rdy !== exp_g[c]) begin
        n_err++;
        $display("FAIL all_rdy c=%0d got=%b exp=%b", c, exu_rdy, exp_g[c]);
      end
      tick();
      n_vec++;
      if (cdb_wr !== 1'b1 || cdb_tag !== m_tag ||
          cdb_wdata !== m_dat || cdb_inst_id !== m_id) begin
        n_err++;
        $display("FAIL all_cdb c=%0d got wr=%b tag=%h d=%h exp 1/%h/%h",
                 c, cdb_wr, cdb_tag, cdb_wdata, m_tag, m_dat);
      end
    end
    exu_req = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    exu_req = 4'b0010;
    tick();
    exu_req = 4'b0011;
    #1;
    n_vec++;
    if (exu_rdy !== 4'b0001) begin
      n_err++;
      $display("FAIL wrap_rdy got=%b exp=0001", exu_rdy);
    end
    tick();
    exu_req = 4'b0010;
    #1;
    n_vec++;
    if (exu_rdy !== 4'b0010) begin
      n_err++;
      $display("FAIL wrap_rdy2 got=%b exp=0010", exu_rdy);
    end
    tick();
    exu_req = '0;
  endtask

  task automatic test_flush();
    do_reset();
    exu_req = 4'b0001;
    tick();
    exu_req = '1;
    flush = 1'b1;
    #1;
    n_vec++;
    if (exu_rdy !== '0 || cdb_wr !== 1'b1) begin
      n_err++;
      $display("FAIL flush_cyc got rdy=%b wr=%b exp rdy=0000 wr=1",
               exu_rdy, cdb_wr);
    end
    tick();
    flush = 1'b0;
    n_vec++;
    if (cdb_wr !== 1'b0) begin
      n_err++;
      $display("FAIL flush_wr got=%b exp=0", cdb_wr);
    end
    #1;
    n_vec++;
    if (exu_rdy !== 4'b0010) begin
      n_err++;
      $display("FAIL flush_resume got=%b exp=0010", exu_rdy);
    end
    tick();
    exu_req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    exu_req = 4'b0100;
    tick();
    exu_req = 4'b1000;
    #1;
    n_vec++;
    if (exu_rdy !== 4'b1000) begin
      n_err++;
      $display("FAIL rmid_pre got=%b exp=1000", exu_rdy);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (exu_rdy !== '0) begin
      n_err++;
      $display("FAIL rmid_rdy got=%b exp=0000", exu_rdy);
    end
    tick();
    n_vec++;
    if (cdb_wr !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_wr got=%b exp=0", cdb_wr);
    end
    rst_n = 1'b1;
    exu_req = 4'b0001;
    #1;
    n_vec++;
    if (exu_rdy !== 4'b0001) begin
      n_err++;
      $display("FAIL rmid_ptr0 got=%b exp=0001", exu_rdy);
    end
    tick();
    exu_req = 4'b1000;
    #1;
    n_vec++;
    if (exu_rdy !== 4'b1000) begin
      n_err++;
      $display("FAIL rmid_post got=%b exp=1000", exu_rdy);
    end
    tick();
    exu_req = '0;
  endtask

  // Requests stay pending until granted; EXU1 never drops its request.
  task automatic test_random();
    logic [N-1:0] g;
    int wait1;
    do_reset();
    rand_payload();
    wait1 = 0;
    exu_req = 4'b0010;
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      #1;
      g = model_grant();
      n_vec++;
      if (exu_rdy !== g) begin
        n_err++;
        $display("FAIL rand_rdy c=%0d got=%b exp=%b", c, exu_rdy, g);
      end
      if (g[1] || !rst_n) wait1 = 0;
      else if (!flush) wait1++;
      n_vec++;
      if (wait1 >= N) begin
        n_err++;
        $display("FAIL rand_fair c=%0d got wait=%0d exp<%0d", c, wait1, N);
      end
      tick();
      n_vec++;
      if (cdb_wr !== m_wr || cdb_tag !== m_tag ||
          cdb_wdata !== m_dat || cdb_inst_id !== m_id) begin
        n_err++;
        $display("FAIL rand_cdb c=%0d got %b/%h/%h/%h exp %b/%h/%h/%h",
                 c, cdb_wr, cdb_tag, cdb_wdata, cdb_inst_id,
                 m_wr, m_tag, m_dat, m_id);
      end
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          t_tag[i] = TW'($urandom);
          t_dat[i] = $urandom;
          t_id[i]  = IW'($urandom);
          if (i != 1) exu_req[i] = 1'b0;
        end
        if (i != 1 && !exu_req[i] && $urandom_range(0, 2) == 0)
          exu_req[i] = 1'b1;
      end
      exu_req[1] = 1'b1;
    end
    rst_n = 1'b1;
    flush = 1'b0;
    exu_req = '0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_ptr = 0; m_wr = 0; m_tag = '0; m_dat = '0; m_id = '0;
    rst_n = 1'b0;
    flush = 1'b0;
    exu_req = '0;
    for (int i = 0; i < N; i++) begin
      t_tag[i] = '0; t_dat[i] = '0; t_id[i] = '0;
    end
    test_reset();
    test_single();
    test_all_req();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
